// File: rtl/sha2_stream_core_if.sv
// Block-level handshake between a message-block source and the SHA-2 compression core.
interface sha2_stream_core_if;
  logic         block_valid;
  logic         block_first;
  logic         mode_224;
  logic [511:0] block;
  logic         block_ready;
  logic [255:0] digest;
  logic         digest_valid;
  logic         busy;

  modport master (
    output block_valid, block_first, mode_224, block,
    input  block_ready, digest, digest_valid, busy
  );

  modport slave (
    input  block_valid, block_first, mode_224, block,
    output block_ready, digest, digest_valid, busy
  );
endinterface

// File: rtl/sha2_stream_core.sv
// SHA-256/SHA-224 block compression core: one 512-bit block per accept,
// ROUNDS_PER_CYCLE chained rounds per clock, 16-word sliding message schedule.
module sha2_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic               clock,
  input  logic               reset,
  sha2_stream_core_if.slave  bus
);

  localparam int R = ROUNDS_PER_CYCLE;

  generate
    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_rounds
      $error("sha2_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_COMPRESS = 2'd1;
  localparam logic [1:0] ST_FINAL    = 2'd2;

  localparam logic [5:0] STEP     = 6'(R);
  localparam logic [5:0] LAST_CNT = 6'(64 - R);

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV_256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:7][31:0] IV_224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic [1:0]  state_reg;
  logic [5:0]  cnt_reg;
  logic        mode_reg;
  logic        dv_reg;
  logic [31:0] h_reg    [0:7];
  logic [31:0] work_reg [0:7];
  logic [31:0] win_reg  [0:15];

  logic [31:0] blk_w    [0:15];
  logic [31:0] ext      [0:15+R];
  logic [31:0] round_v  [0:7];
  logic        mode_sel;
  logic        accept;

  assign mode_sel = SUPPORT_224 && bus.mode_224;
  assign accept   = (state_reg == ST_IDLE) && bus.block_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_blk_words
      assign blk_w[gi] = bus.block[511-32*gi -: 32];
    end
  endgenerate

  // ext[0..15] is W[t..t+15]; ext[16..15+R] are the R words the window needs next.
  always_comb begin
    for (int k = 0; k < 16; k++) ext[k] = win_reg[k];
    for (int j = 0; j < R; j++) begin
      ext[16+j] = small_s1(ext[14+j]) + ext[9+j] + small_s0(ext[1+j]) + ext[j];
    end
  end

  always_comb begin : rounds_comb
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = '0;
    t2 = '0;
    for (int k = 0; k < 8; k++) round_v[k] = work_reg[k];
    for (int i = 0; i < R; i++) begin
      t1 = round_v[7] + big_s1(round_v[4])
         + ((round_v[4] & round_v[5]) ^ (~round_v[4] & round_v[6]))
         + K[cnt_reg + 6'(i)] + ext[i];
      t2 = big_s0(round_v[0])
         + ((round_v[0] & round_v[1]) ^ (round_v[0] & round_v[2]) ^ (round_v[1] & round_v[2]));
      round_v[7] = round_v[6];
      round_v[6] = round_v[5];
      round_v[5] = round_v[4];
      round_v[4] = round_v[3] + t1;
      round_v[3] = round_v[2];
      round_v[2] = round_v[1];
      round_v[1] = round_v[0];
      round_v[0] = t1 + t2;
    end
  end

  // Working variables and schedule window carry no reset; only control and H do.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      dv_reg    <= 1'b0;
      mode_reg  <= 1'b0;
      for (int k = 0; k < 8; k++) h_reg[k] <= IV_256[k];
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg <= ST_COMPRESS;
            cnt_reg   <= '0;
            dv_reg    <= 1'b0;
            for (int k = 0; k < 16; k++) win_reg[k] <= blk_w[k];
            if (bus.block_first) begin
              mode_reg <= mode_sel;
              for (int k = 0; k < 8; k++) begin
                h_reg[k]    <= mode_sel ? IV_224[k] : IV_256[k];
                work_reg[k] <= mode_sel ? IV_224[k] : IV_256[k];
              end
            end else begin
              for (int k = 0; k < 8; k++) work_reg[k] <= h_reg[k];
            end
          end
        end
        ST_COMPRESS: begin
          for (int k = 0; k < 8; k++) work_reg[k] <= round_v[k];
          for (int k = 0; k < 16; k++) win_reg[k] <= ext[k+R];
          cnt_reg <= cnt_reg + STEP;
          if (cnt_reg == LAST_CNT) state_reg <= ST_FINAL;
        end
        ST_FINAL: begin
          for (int k = 0; k < 8; k++) h_reg[k] <= h_reg[k] + work_reg[k];
          dv_reg    <= 1'b1;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.block_ready  = (state_reg == ST_IDLE);
  assign bus.busy         = (state_reg != ST_IDLE);
  assign bus.digest_valid = dv_reg;

  generate
    for (gi = 0; gi < 8; gi++) begin : g_digest
      assign bus.digest[255-32*gi -: 32] = (gi == 7 && mode_reg) ? 32'h0 : h_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_sha2_stream_core.sv
// Runs three cores (1, 2 and 4 rounds/cycle) against a plain SHA-256 block model
// plus a cycle-count protocol model; known-answer digests pin both.
module tb_sha2_stream_core;

  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] TWO_B1 = 512'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000;
  localparam logic [511:0] TWO_B2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clock = 1'b0;
  logic         rst_n    [3];
  logic         vld      [3];
  logic         first_in [3];
  logic         mode_in  [3];
  logic [511:0] blk      [3];
  logic         rdy      [3];
  logic         dv       [3];
  logic         busy_o   [3];
  logic [255:0] dig      [3];

  int checks   = 0;
  int failures = 0;

  // Reference model state, one slot per core.
  int           m_rem  [3];
  bit           m_dv   [3];
  bit           m_mode [3];
  bit           m_init [3];
  logic [255:0] m_h    [3];
  logic [255:0] m_pend [3];

  always #5 clock = ~clock;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      sha2_stream_core_if bus ();
      assign bus.block_valid = vld[gi];
      assign bus.block_first = first_in[gi];
      assign bus.mode_224    = mode_in[gi];
      assign bus.block       = blk[gi];
      assign rdy[gi]         = bus.block_ready;
      assign dv[gi]          = bus.digest_valid;
      assign busy_o[gi]      = bus.busy;
      assign dig[gi]         = bus.digest;
      sha2_stream_core #(.ROUNDS_PER_CYCLE(1 << gi), .SUPPORT_224(1'b1)) dut (
        .clock (clock),
        .reset (rst_n[gi]),
        .bus   (bus)
      );
    end
  endgenerate

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression of one block, returning the updated chaining value.
  function automatic logic [255:0] sha_block(input logic [255:0] hin, input logic [511:0] m);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = m[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int k = 0; k < 8; k++) v[k] = hin[255-32*k -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int k = 0; k < 8; k++) r[255-32*k -: 32] = hin[255-32*k -: 32] + v[k];
    return r;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int k = 0; k < 16; k++) b[511-32*k -: 32] = $urandom;
    return b;
  endfunction

  task automatic chk(input string name, input int i, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, i, act, exp);
    end
  endtask

  // Protocol model: an accepted block keeps the core busy for 64/R+1 edges.
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i] === 1'b0) begin
        m_init[i] <= 1'b1;
        m_rem[i]  <= 0;
        m_dv[i]   <= 1'b0;
        m_mode[i] <= 1'b0;
        m_h[i]    <= IV256;
      end else if (m_init[i]) begin
        if (m_rem[i] == 0) begin
          if (vld[i]) begin
            m_rem[i] <= (64 >> i) + 1;
            m_dv[i]  <= 1'b0;
            if (first_in[i]) m_mode[i] <= mode_in[i];
            m_pend[i] <= sha_block(first_in[i] ? (mode_in[i] ? IV224 : IV256) : m_h[i], blk[i]);
          end
        end else begin
          m_rem[i] <= m_rem[i] - 1;
          if (m_rem[i] == 1) begin
            m_h[i]  <= m_pend[i];
            m_dv[i] <= 1'b1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) begin
        if (m_init[i]) begin
          chk("ready", i, 256'(rdy[i]), 256'(m_rem[i] == 0));
          chk("busy", i, 256'(busy_o[i]), 256'(m_rem[i] != 0));
          chk("dvalid", i, 256'(dv[i]), 256'(m_dv[i]));
          if (m_dv[i]) chk("digest", i, dig[i], m_mode[i] ? {m_h[i][255:32], 32'h0} : m_h[i]);
        end
      end
    end
  end

  task automatic wait_ready(input int i);
    int n = 0;
    while (!rdy[i] && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (!rdy[i]) chk("ready_timeout", i, 256'(rdy[i]), 256'(1));
  endtask

  task automatic send(input int i, input logic [511:0] b, input logic f, input logic md);
    wait_ready(i);
    blk[i] = b; first_in[i] = f; mode_in[i] = md; vld[i] = 1'b1;
    $display("dut%0d send first=%0d mode_224=%0d block=%h", i, f, md, b);
    @(negedge clock);
    vld[i] = 1'b0; blk[i] = rand_block();
    first_in[i] = 1'($urandom); mode_in[i] = 1'($urandom);
  endtask

  task automatic wait_digest(input int i, input int lat);
    int n = 0;
    while (!dv[i] && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("latency", i, 256'(n), 256'(lat));
  endtask

  task automatic run(input int i);
    int lat = (64 >> i) + 1;
    int last = -1;
    int n_acc = 0;
    // Reset with a block on the bus: it must be dropped.
    rst_n[i] = 1'b0; vld[i] = 1'b1; blk[i] = ABC_BLK; first_in[i] = 1'b1; mode_in[i] = 1'b0;
    repeat (3) @(negedge clock);
    rst_n[i] = 1'b1; vld[i] = 1'b0;
    chk("reset_ready", i, 256'(rdy[i]), 256'(1));
    chk("reset_busy", i, 256'(busy_o[i]), 256'(0));
    chk("reset_dvalid", i, 256'(dv[i]), 256'(0));
    chk("reset_h", i, dig[i], IV256);

    send(i, ABC_BLK, 1'b1, 1'b0);
    wait_digest(i, lat);
    chk("abc256", i, dig[i], ABC256);

    send(i, ABC_BLK, 1'b1, 1'b1);
    wait_digest(i, lat);
    chk("abc224", i, dig[i], ABC224);

    send(i, TWO_B1, 1'b1, 1'b0);
    wait_digest(i, lat);
    send(i, TWO_B2, 1'b0, 1'b1);
    wait_digest(i, lat);
    chk("two_block", i, dig[i], TWO256);

    // Valid held high: accepts must be exactly 64/R+2 cycles apart.
    vld[i] = 1'b1; first_in[i] = 1'b1; mode_in[i] = 1'b0; blk[i] = rand_block();
    for (int c = 0; c < 4 * (lat + 1); c++) begin
      if (rdy[i]) begin
        if (last >= 0) chk("spacing", i, 256'(c - last), 256'(lat + 1));
        last = c;
        n_acc++;
      end
      @(negedge clock);
      blk[i] = rand_block();
    end
    vld[i] = 1'b0;
    chk("accepts", i, 256'(n_acc), 256'(4));
    wait_ready(i);

    // Reset around round 30, then chain from the restored IV.
    send(i, ABC_BLK, 1'b1, 1'b1);
    repeat (30 >> i) @(negedge clock);
    rst_n[i] = 1'b0;
    @(negedge clock);
    rst_n[i] = 1'b1;
    chk("midreset_ready", i, 256'(rdy[i]), 256'(1));
    chk("midreset_dvalid", i, 256'(dv[i]), 256'(0));
    chk("midreset_busy", i, 256'(busy_o[i]), 256'(0));
    send(i, ABC_BLK, 1'b0, 1'b1);
    wait_digest(i, lat);
    chk("chain_iv", i, dig[i], ABC256);

    repeat (400) begin
      @(negedge clock);
      rst_n[i]    = ($urandom_range(0, 199) != 0);
      vld[i]      = ($urandom_range(0, 2) == 0);
      first_in[i] = 1'($urandom);
      mode_in[i]  = 1'($urandom);
      blk[i]      = rand_block();
    end
    @(negedge clock);
    rst_n[i] = 1'b1; vld[i] = 1'b0;
    wait_ready(i);
    @(negedge clock);
  endtask

  initial begin
    logic [255:0] tmp;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; vld[i] = 1'b0; first_in[i] = 1'b0; mode_in[i] = 1'b0; blk[i] = '0;
      m_init[i] = 1'b0;
    end
    chk("model_abc256", 0, sha_block(IV256, ABC_BLK), ABC256);
    tmp = sha_block(IV224, ABC_BLK);
    chk("model_abc224", 0, {tmp[255:32], 32'h0}, ABC224);
    chk("model_two", 0, sha_block(sha_block(IV256, TWO_B1), TWO_B2), TWO256);
    fork
      run(0);
      run(1);
      run(2);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sha2_stream_core.md
SHA2_STREAM_CORE -- requirements
Module: sha2_stream_core

Interface
REQ-001 SHALL have parameter ROUNDS_PER_CYCLE, default 1, number of compression rounds per clock; legal values 1, 2, 4; other values SHALL fail elaboration.
REQ-002 SHALL have parameter SUPPORT_224, default 1, enables SHA-224 mode; when 0, mode_224 SHALL be ignored and treated as 0.
REQ-003 clock  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low; sampled on rising edge of clock.
REQ-005 block_valid  in  1  a 512-bit message block is presented.
REQ-006 block_first  in  1  1 = first block of a message (load IV); 0 = chain from current digest.
REQ-007 mode_224  in  1  1 = SHA-224; sampled only when a block_first block is accepted.
REQ-008 block  in  512  padded block, word 0 in bits [511:480].
REQ-009 block_ready  out  1  core can accept a block this cycle.
REQ-010 digest  out  256  {H0..H7}; in SHA-224 mode {H0..H6, 32'h0}.
REQ-011 digest_valid  out  1  digest holds the result of the last accepted block.
REQ-012 busy  out  1  compression in progress.

Function
REQ-013 SHALL implement FSM IDLE, COMPRESS, FINAL; block_ready=1 only in IDLE; busy=1 in COMPRESS and FINAL.
REQ-014 Accept = block_valid && block_ready at a rising edge; IDLE->COMPRESS on accept; block_valid outside IDLE SHALL be ignored, with no queuing.
REQ-015 On accept with block_first=1: H0..H7 and a..h SHALL load the IV for the latched mode (SHA-256 6a09e667..5be0cd19; SHA-224 c1059ed8..befa4fa4).
REQ-016 On accept with block_first=0: a..h SHALL load current H0..H7; latched mode is unchanged.
REQ-017 On accept, block SHALL be captured into a 16-word schedule window; digest_valid SHALL clear.
REQ-018 COMPRESS SHALL last exactly 64/ROUNDS_PER_CYCLE cycles, with ROUNDS_PER_CYCLE chained rounds per cycle using standard SHA-256 round functions and K[0..63].
REQ-019 Schedule: W[t] for t<16 comes from block; for t>=16 W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32. Storage SHALL be a sliding 16-word window, not 64 words.
REQ-020 A 6-bit round counter SHALL advance by ROUNDS_PER_CYCLE per COMPRESS cycle; after the cycle processing round 63, the FSM SHALL go COMPRESS->FINAL.
REQ-021 FINAL (1 cycle): Hi <= Hi + working var mod 2^32 for all eight; digest_valid <= 1; FINAL->IDLE.
REQ-022 Latency: accept at edge N -> digest_valid=1 and block_ready=1 after edge N+64/ROUNDS_PER_CYCLE+1.
REQ-023 digest_valid SHALL stay 1 until the next accept or reset; digest SHALL be stable while digest_valid=1.
REQ-024 Accept in the same cycle FINAL->IDLE completes is impossible (block_ready=0 in FINAL); the first accept is the edge after digest_valid rises, giving back-to-back throughput of one block per 64/R+2 cycles.
REQ-025 block_first=0 after reset with no prior message SHALL chain from the SHA-256 IV.
REQ-026 block, block_first and mode_224 are not required stable after accept.

Reset
REQ-027 reset=0 at an edge SHALL force state=IDLE, round counter=0, digest_valid=0, busy=0, block_ready=1, H0..H7=SHA-256 IV, latched mode=SHA-256, from any state including mid-COMPRESS.
REQ-028 reset has priority over accept; a block presented during reset SHALL be dropped.
REQ-029 Working variables and schedule need no reset value.

Verification
REQ-030 R=1: accept "abc" block (61626380, 14x00000000, 00000018), first=1, mode_224=0 -> after 65 edges digest=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, digest_valid=1.
REQ-031 Same block, mode_224=1 -> digest=23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
REQ-032 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (block 2: 15x00000000, 000001c0; first=1 then 0) -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
REQ-033 R=2 and R=4 rerun REQ-030 -> identical digest, digest_valid after 33 and 17 edges respectively.
REQ-034 Hold block_valid=1 continuously -> exactly one accept per 64/R+2 cycles; block_ready=0 throughout COMPRESS/FINAL.
REQ-035 Assert reset at COMPRESS round 30 -> next cycle block_ready=1, digest_valid=0, busy=0; a subsequent first=0 "abc" block yields the REQ-030 digest.
